// File: rtl/mux_scan_capture.sv
// Scan controller for the 7-to-1 switch mux: steps the select through every channel,
// samples once per channel after a fixed dwell and publishes a whole frame at a time.
`timescale 1ns/1ps

module mux_scan_capture #(
  parameter int PERIOD = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_in,
  output logic [2:0] sel,
  output logic [2:0] chan,
  output logic [6:0] pattern,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DWELL  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Channel order is fixed by the mux decode; code 3'd5 is never driven.
  function automatic logic [2:0] chan_code(input logic [2:0] ch);
    logic [2:0] code;
    case (ch)
      3'd0:    code = 3'd0;
      3'd1:    code = 3'd1;
      3'd2:    code = 3'd2;
      3'd3:    code = 3'd3;
      3'd4:    code = 3'd6;
      3'd5:    code = 3'd7;
      3'd6:    code = 3'd4;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     chan_q, chan_d;
  logic [2:0]     sel_q, sel_d;
  logic [6:0]     shadow_q, shadow_d;
  logic [6:0]     pattern_q, pattern_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DWELL;
        else       state_d = S_IDLE;
      end
      S_DWELL: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             state_d = S_DWELL;
      end
      S_SAMPLE: begin
        if (chan_q == 3'd6) state_d = S_DONE;
        else                state_d = S_DWELL;
      end
      S_DONE: begin
        if (continuous) state_d = S_DWELL;
        else            state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; sel/chan only move on DWELL entry.
  always_comb begin
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    pattern_d = pattern_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chan_d = 3'd0;
          sel_d  = chan_code(3'd0);
          cnt_d  = RELOAD;
        end else begin
          cnt_d  = cnt_q;
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             cnt_d = cnt_q;
      end
      S_SAMPLE: begin
        shadow_d[chan_q] = mux_in;
        if (chan_q == 3'd6) begin
          pattern_d = {mux_in, shadow_q[5:0]};
        end else begin
          chan_d = chan_q + 3'd1;
          sel_d  = chan_code(chan_q + 3'd1);
          cnt_d  = RELOAD;
        end
      end
      S_DONE: begin
        if (continuous) begin
          chan_d = 3'd0;
          sel_d  = chan_code(3'd0);
          cnt_d  = RELOAD;
        end else begin
          cnt_d  = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_SAMPLE) && (chan_q == 3'd6);
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      chan_q    <= 3'd0;
      sel_q     <= 3'd0;
      shadow_q  <= 7'd0;
      pattern_q <= 7'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel        = sel_q;
  assign chan       = chan_q;
  assign pattern    = pattern_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
